// File: rtl/wb_trace_buffer.sv
// Write-back commit trace buffer.
// Records {pc, rd, data} for every architectural register write leaving
// MEM/WB into a circular buffer. Three capture modes are supported: continuous
// wrap, stop-when-full, and PC trigger with a post-trigger depth. A frozen
// trace drains through a valid/ready read port.
module wb_trace_buffer #(
  parameter  int XLEN  = 32,
  parameter  int RD_W  = 5,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [RD_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] wb_pc,
  input  logic            arm,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [AW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [RD_W-1:0] rd_rd,
  output logic [XLEN-1:0] rd_data,
  output logic [AW:0]     count,
  output logic            capturing,
  output logic            frozen,
  output logic            triggered,
  output logic [15:0]     overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_POST, S_FROZEN} state_t;

  // Mode 2'b11 matches neither code below, so it falls through to wrap.
  localparam logic [1:0]  M_STOP   = 2'b01;
  localparam logic [1:0]  M_TRIG   = 2'b10;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t            state;
  logic [AW-1:0]     wr_ptr, rd_ptr, remaining, post_q;
  logic [1:0]        mode_q;
  logic [XLEN-1:0]   trig_pc_q;

  logic [XLEN-1:0]   mem_pc   [DEPTH];
  logic [RD_W-1:0]   mem_rd   [DEPTH];
  logic [XLEN-1:0]   mem_data [DEPTH];

  logic cap_ev, full, pop, pc_hit;

  // Event qualification; x0 writes never enter the trace.
  always_comb begin
    cap_ev = wb_valid && (wb_rd != '0) && (state == S_CAPTURE || state == S_POST);
    full   = (count == FULL_CNT);
    pop    = rd_valid && rd_ready;
    pc_hit = (state == S_CAPTURE) && (mode_q == M_TRIG) && (wb_pc == trig_pc_q);
  end

  assign rd_valid  = (state == S_IDLE || state == S_FROZEN) && (count != '0);
  assign capturing = (state == S_CAPTURE || state == S_POST);
  assign frozen    = (state == S_FROZEN);
  assign rd_pc     = mem_pc[rd_ptr];
  assign rd_rd     = mem_rd[rd_ptr];
  assign rd_data   = mem_data[rd_ptr];

  // Entry storage; cleared on reset so the read outputs come up as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (!arm && cap_ev) begin
      mem_pc[wr_ptr]   <= wb_pc;
      mem_rd[wr_ptr]   <= wb_rd;
      mem_data[wr_ptr] <= wb_data;
    end
  end

  // Capture/read control FSM with pointers, occupancy and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= '0;
      triggered <= 1'b0;
      remaining <= '0;
      mode_q    <= '0;
      trig_pc_q <= '0;
      post_q    <= '0;
    end else if (arm) begin
      // Arm wins over a coincident capture event or read.
      state     <= S_CAPTURE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= '0;
      triggered <= 1'b0;
      remaining <= '0;
      mode_q    <= mode;
      trig_pc_q <= trig_pc;
      post_q    <= post_count;
    end else begin
      case (state)
        S_CAPTURE, S_POST: begin
          if (cap_ev) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) begin
              // Oldest entry is overwritten; the read side follows along.
              rd_ptr <= rd_ptr + 1'b1;
              if (overflow != 16'hFFFF) overflow <= overflow + 16'd1;
            end else begin
              count <= count + 1'b1;
            end
            if (mode_q == M_STOP && count == FULL_CNT - 1'b1) begin
              state <= S_FROZEN;
            end else if (pc_hit) begin
              triggered <= 1'b1;
              if (post_q == '0) begin
                state <= S_FROZEN;
              end else begin
                state     <= S_POST;
                remaining <= post_q;
              end
            end else if (state == S_POST) begin
              remaining <= remaining - 1'b1;
              if (remaining == AW'(1)) state <= S_FROZEN;
            end
          end
        end
        default: begin
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (state == S_FROZEN && count == (AW+1)'(1)) state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer (DEPTH=4): directed scenarios
// followed by a randomized phase, all compared to a queue-based model.
module tb_wb_trace_buffer;
  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 0;
  logic            rst_n;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data, wb_pc, trig_pc;
  logic            arm;
  logic [1:0]      mode;
  logic [AW-1:0]   post_count;
  logic            rd_valid, rd_ready;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [RD_W-1:0] rd_rd;
  logic [AW:0]     count;
  logic            capturing, frozen, triggered;
  logic [15:0]     overflow;

  wb_trace_buffer #(.XLEN(XLEN), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .arm(arm), .mode(mode),
    .trig_pc(trig_pc), .post_count(post_count), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_data(rd_data),
    .count(count), .capturing(capturing), .frozen(frozen),
    .triggered(triggered), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the trace is a plain queue, oldest at the front.
  typedef struct { logic [XLEN-1:0] pc; logic [RD_W-1:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t q[$];
  int   m_ovf, m_mode, m_post, m_rem;
  logic [XLEN-1:0] m_tpc;
  bit   m_cap, m_inpost, m_frz, m_trig;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_ovf = 0; m_mode = 0; m_post = 0; m_rem = 0; m_tpc = '0;
    m_cap = 0; m_inpost = 0; m_frz = 0; m_trig = 0;
  endtask

  task automatic model_freeze();
    m_cap = 0; m_inpost = 0; m_frz = 1;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    ent_t e;
    if (arm) begin
      q.delete(); m_ovf = 0; m_trig = 0;
      m_mode = int'(mode); m_tpc = trig_pc; m_post = int'(post_count);
      m_cap = 1; m_inpost = 0; m_frz = 0;
    end else if (m_cap) begin
      if (wb_valid && wb_rd != 0) begin
        e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
        q.push_back(e);
        if (q.size() > DEPTH) begin
          void'(q.pop_front());
          if (m_ovf < 65535) m_ovf++;
        end
        if (m_mode == 1 && q.size() == DEPTH) model_freeze();
        else if (m_mode == 2 && !m_inpost && wb_pc == m_tpc) begin
          m_trig = 1;
          if (m_post == 0) model_freeze();
          else begin m_inpost = 1; m_rem = m_post; end
        end else if (m_inpost) begin
          m_rem--;
          if (m_rem == 0) model_freeze();
        end
      end
    end else if (q.size() > 0 && rd_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) m_frz = 0;
    end
  endtask

  task automatic compare_all();
    bit mv;
    mv = !m_cap && q.size() > 0;
    chk("count", 64'(count), 64'(q.size()));
    chk("capturing", 64'(capturing), 64'(m_cap));
    chk("frozen", 64'(frozen), 64'(m_frz));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_valid", 64'(rd_valid), 64'(mv));
    if (mv) begin
      chk("rd_pc", 64'(rd_pc), 64'(q[0].pc));
      chk("rd_rd", 64'(rd_rd), 64'(q[0].rd));
      chk("rd_data", 64'(rd_data), 64'(q[0].data));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [XLEN-1:0] tpc, input int pc_n);
    arm = 1; mode = m; trig_pc = tpc; post_count = AW'(pc_n);
    tick();
    arm = 0;
  endtask

  task automatic wb(input int rd, input logic [XLEN-1:0] data, input logic [XLEN-1:0] pc);
    wb_valid = 1; wb_rd = RD_W'(rd); wb_data = data; wb_pc = pc;
    tick();
    wb_valid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, 64'(count), 0);
    chk({tag, "_flags"}, 64'({rd_valid, capturing, frozen, triggered}), 0);
    chk({tag, "_overflow"}, 64'(overflow), 0);
    chk({tag, "_rd_pc"}, 64'(rd_pc), 0);
    chk({tag, "_rd_rd"}, 64'(rd_rd), 0);
    chk({tag, "_rd_data"}, 64'(rd_data), 0);
  endtask

  initial begin
    int exp_rd[4];
    logic [XLEN-1:0] exp_pc[4];
    logic [XLEN-1:0] pcs[8];

    rst_n = 0; wb_valid = 0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    arm = 0; mode = '0; trig_pc = '0; post_count = '0; rd_ready = 0;
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    wb(1, 32'hAA, 32'h40);
    chk("idle_no_capture", 64'(count), 0);

    // WRAP overwrite
    do_arm(2'b00, '0, 0);
    for (int i = 1; i <= 6; i++) wb(i, 32'(i * 10), 32'(i * 4));
    chk("wrap_count", 64'(count), 4);
    chk("wrap_overflow", 64'(overflow), 2);
    do_arm(2'b00, '0, 0);
    chk("rearm_count", 64'(count), 0);
    chk("rearm_overflow", 64'(overflow), 0);

    // x0 filtering and STOPFULL
    do_arm(2'b01, '0, 0);
    wb(0, 1, 32'h100); wb(3, 3, 32'h104); wb(0, 2, 32'h108);
    wb(5, 5, 32'h10C); wb(6, 6, 32'h110); wb(7, 7, 32'h114);
    chk("stopfull_frozen", 64'(frozen), 1);
    wb(8, 8, 32'h118);
    chk("stopfull_x8_dropped", 64'(count), 4);
    exp_rd = '{3, 5, 6, 7};
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_rd", 64'(rd_rd), 64'(exp_rd[i]));
      tick();
    end
    chk("drain_idle", 64'({frozen, rd_valid}), 0);
    rd_ready = 0;

    // TRIGGER with post_count=2
    do_arm(2'b10, 32'h20, 2);
    for (int i = 0; i < 8; i++) begin
      wb(i + 1, 32'(i), 32'h10 + 32'(i * 4));
      if (i == 6) chk("trig_frozen_after_28", 64'(frozen), 1);
    end
    chk("trig_triggered", 64'(triggered), 1);
    exp_pc = '{32'h1C, 32'h20, 32'h24, 32'h28};
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("trig_drain_pc", 64'(rd_pc), 64'(exp_pc[i]));
      tick();
    end
    rd_ready = 0;

    // TRIGGER with post_count=0, match on first event
    do_arm(2'b10, 32'h80, 0);
    wb(9, 32'h99, 32'h80);
    chk("post0_frozen", 64'(frozen), 1);
    chk("post0_count", 64'(count), 1);

    // arm coinciding with a read in FROZEN
    rd_ready = 1;
    do_arm(2'b00, '0, 0);
    rd_ready = 0;
    chk("arm_vs_read_count", 64'(count), 0);
    chk("arm_vs_read_capturing", 64'(capturing), 1);

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      arm = ($urandom_range(0, 39) == 0);
      mode = 2'($urandom_range(0, 3));
      trig_pc = 32'h200 + 32'($urandom_range(0, 7) * 4);
      post_count = AW'($urandom_range(0, DEPTH - 1));
      wb_valid = $urandom_range(0, 3) != 0;
      wb_rd = RD_W'($urandom_range(0, 7));
      wb_data = $urandom;
      wb_pc = 32'h200 + 32'($urandom_range(0, 7) * 4);
      rd_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    arm = 0; wb_valid = 0; rd_ready = 0;

    // Asynchronous reset mid-POST
    do_arm(2'b10, 32'h300, 3);
    wb(1, 1, 32'h300);
    wb(2, 2, 32'h304);
    chk("midpost_capturing", 64'(capturing), 1);
    #2 rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
